// File: rtl/fwd_hazard_unit.sv
// fwd_hazard_unit
// Forwarding and hazard unit sitting behind the decode/ALU pipeline register.
// Keeps shadow copies of the MEM- and WB-stage destinations/results, picks the
// ALU operand sources, and raises a stall for load-use hazards and data-cache
// waits.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   exRs1Addr/exRs2Addr       EX source addresses
//   exRs1Data/exRs2Data       EX register-file operands
//   exRdAddr/exRegWrite       EX destination and write enable
//   exIsLoad/exResult         EX load flag and ALU result
//   idRs1Addr/idRs2Addr       decode-stage source addresses
//   memLoadData/memWait       data-cache read data and not-ready flag
//   fwdData1/fwdData2         forwarded ALU operands
//   fwdSel1/fwdSel2           0 = register file, 1 = MEM shadow, 2 = WB shadow
//   stall                     freeze fetch/decode, zero the decode/ALU register
//   stallCount                saturating count of stalled cycles
module fwd_hazard_unit #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] exRs1Addr,
    input  logic [ADDR_W-1:0] exRs2Addr,
    input  logic [DATA_W-1:0] exRs1Data,
    input  logic [DATA_W-1:0] exRs2Data,
    input  logic [ADDR_W-1:0] exRdAddr,
    input  logic              exRegWrite,
    input  logic              exIsLoad,
    input  logic [DATA_W-1:0] exResult,
    input  logic [ADDR_W-1:0] idRs1Addr,
    input  logic [ADDR_W-1:0] idRs2Addr,
    input  logic [DATA_W-1:0] memLoadData,
    input  logic              memWait,
    output logic [DATA_W-1:0] fwdData1,
    output logic [DATA_W-1:0] fwdData2,
    output logic [1:0]        fwdSel1,
    output logic [1:0]        fwdSel2,
    output logic              stall,
    output logic [CNT_W-1:0]  stallCount
);

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_LOADUSE = 2'd1,
        ST_WAIT    = 2'd2
    } state_t;

    localparam logic [1:0] SEL_RF  = 2'd0;
    localparam logic [1:0] SEL_MEM = 2'd1;
    localparam logic [1:0] SEL_WB  = 2'd2;

    logic [ADDR_W-1:0] mem_rd_q;
    logic              mem_we_q;
    logic              mem_is_load_q;
    logic [DATA_W-1:0] mem_val_q;
    logic [ADDR_W-1:0] wb_rd_q;
    logic              wb_we_q;
    logic [DATA_W-1:0] wb_val_q;
    state_t            state_q;
    state_t            state_d;
    logic              stall_d;
    logic              load_use_d;
    logic [CNT_W-1:0]  stall_cnt_q;
    logic [1:0]        sel1_d;
    logic [1:0]        sel2_d;

    // Source priority for one operand. A load sitting in MEM has no data yet,
    // so it is skipped; the load-use stall guarantees the consumer only gets
    // here once that load has reached WB.
    function automatic logic [1:0] pick_src(
        input logic [ADDR_W-1:0] src,
        input logic [ADDR_W-1:0] m_rd,
        input logic              m_we,
        input logic              m_ld,
        input logic [ADDR_W-1:0] w_rd,
        input logic              w_we
    );
        logic [1:0] sel;
        if (src == {ADDR_W{1'b0}}) begin
            sel = SEL_RF;
        end else if (m_we && (m_rd == src) && !m_ld) begin
            sel = SEL_MEM;
        end else if (w_we && (w_rd == src)) begin
            sel = SEL_WB;
        end else begin
            sel = SEL_RF;
        end
        return sel;
    endfunction

    // Operand source selection and data muxing for both ALU operands.
    always_comb begin
        sel1_d = pick_src(exRs1Addr, mem_rd_q, mem_we_q, mem_is_load_q, wb_rd_q, wb_we_q);
        sel2_d = pick_src(exRs2Addr, mem_rd_q, mem_we_q, mem_is_load_q, wb_rd_q, wb_we_q);
        case (sel1_d)
            SEL_MEM: fwdData1 = mem_val_q;
            SEL_WB:  fwdData1 = wb_val_q;
            default: fwdData1 = exRs1Data;
        endcase
        case (sel2_d)
            SEL_MEM: fwdData2 = mem_val_q;
            SEL_WB:  fwdData2 = wb_val_q;
            default: fwdData2 = exRs2Data;
        endcase
    end

    // Stall decision and next state; memWait outranks the load-use hazard.
    always_comb begin
        load_use_d = exIsLoad && exRegWrite && (exRdAddr != {ADDR_W{1'b0}}) &&
                     ((exRdAddr == idRs1Addr) || (exRdAddr == idRs2Addr));
        stall_d = 1'b0;
        state_d = state_q;
        if (rst) begin
            stall_d = 1'b0;
            state_d = ST_RUN;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (memWait) begin
                        stall_d = 1'b1;
                        state_d = ST_WAIT;
                    end else if (load_use_d) begin
                        stall_d = 1'b1;
                        state_d = ST_LOADUSE;
                    end else begin
                        stall_d = 1'b0;
                        state_d = ST_RUN;
                    end
                end
                // The bubble is already in EX; nothing more to hold.
                ST_LOADUSE: begin
                    stall_d = 1'b0;
                    if (memWait) begin
                        state_d = ST_WAIT;
                    end else begin
                        state_d = ST_RUN;
                    end
                end
                ST_WAIT: begin
                    if (memWait) begin
                        stall_d = 1'b1;
                        state_d = ST_WAIT;
                    end else begin
                        stall_d = 1'b0;
                        state_d = ST_RUN;
                    end
                end
                default: begin
                    stall_d = 1'b0;
                    state_d = ST_RUN;
                end
            endcase
        end
    end

    // State, saturating stall counter and MEM/WB shadow pipeline.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_RUN;
            stall_cnt_q   <= {CNT_W{1'b0}};
            mem_rd_q      <= {ADDR_W{1'b0}};
            mem_we_q      <= 1'b0;
            mem_is_load_q <= 1'b0;
            mem_val_q     <= {DATA_W{1'b0}};
            wb_rd_q       <= {ADDR_W{1'b0}};
            wb_we_q       <= 1'b0;
            wb_val_q      <= {DATA_W{1'b0}};
        end else begin
            state_q <= state_d;
            if (stall_d && (stall_cnt_q != {CNT_W{1'b1}})) begin
                stall_cnt_q <= stall_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
            end
            if (!memWait) begin
                mem_rd_q      <= exRdAddr;
                mem_we_q      <= exRegWrite;
                mem_is_load_q <= exIsLoad;
                mem_val_q     <= exResult;
                wb_rd_q       <= mem_rd_q;
                wb_we_q       <= mem_we_q;
                wb_val_q      <= mem_is_load_q ? memLoadData : mem_val_q;
            end
        end
    end

    assign fwdSel1    = sel1_d;
    assign fwdSel2    = sel2_d;
    assign stall      = stall_d;
    assign stallCount = stall_cnt_q;

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Testbench for fwd_hazard_unit: directed scenarios plus random traffic, with
// a reference model that tracks in-flight producers as a short instruction
// history. Expected outputs go into a scoreboard queue that a separate
// monitor drains on the falling clock edge.
module tb_fwd_hazard_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [4:0]  exRs1Addr = 5'd0, exRs2Addr = 5'd0, exRdAddr = 5'd0;
    logic [31:0] exRs1Data = 32'd0, exRs2Data = 32'd0, exResult = 32'd0;
    logic        exRegWrite = 1'b0, exIsLoad = 1'b0, memWait = 1'b0;
    logic [4:0]  idRs1Addr = 5'd0, idRs2Addr = 5'd0;
    logic [31:0] memLoadData = 32'd0;
    logic [31:0] fwdData1, fwdData2;
    logic [1:0]  fwdSel1, fwdSel2;
    logic        stall;
    logic [15:0] stallCount;

    fwd_hazard_unit #(.DATA_W(32), .ADDR_W(5), .CNT_W(16)) dut (
        .clk(clk), .rst(rst),
        .exRs1Addr(exRs1Addr), .exRs2Addr(exRs2Addr),
        .exRs1Data(exRs1Data), .exRs2Data(exRs2Data),
        .exRdAddr(exRdAddr), .exRegWrite(exRegWrite), .exIsLoad(exIsLoad),
        .exResult(exResult), .idRs1Addr(idRs1Addr), .idRs2Addr(idRs2Addr),
        .memLoadData(memLoadData), .memWait(memWait),
        .fwdData1(fwdData1), .fwdData2(fwdData2),
        .fwdSel1(fwdSel1), .fwdSel2(fwdSel2),
        .stall(stall), .stallCount(stallCount)
    );

    always #5 clk = ~clk;

    // Staged inputs for the next cycle.
    logic        n_rst, n_exRegWrite, n_exIsLoad, n_memWait;
    logic [4:0]  n_exRs1Addr, n_exRs2Addr, n_exRdAddr, n_idRs1Addr, n_idRs2Addr;
    logic [31:0] n_exRs1Data, n_exRs2Data, n_exResult, n_memLoadData;

    // Reference model: in-flight instruction history (0 = in MEM, 1 = in WB).
    typedef struct {
        logic [4:0]  rd;
        logic        we;
        logic        ld;
        logic [31:0] val;
    } rec_t;
    rec_t        hist[2];
    int          m_mode;      // 0 running, 1 bubble cycle, 2 cache wait
    int          m_next_mode;
    logic [15:0] m_cnt;
    logic        m_stall;

    typedef struct packed {
        logic [1:0]  s1;
        logic [31:0] d1;
        logic [1:0]  s2;
        logic [31:0] d2;
        logic        st;
        logic [15:0] cnt;
    } exp_t;
    exp_t sb[$];

    int checks = 0;
    int errors = 0;

    task automatic clear_hist();
        for (int i = 0; i < 2; i++) begin
            hist[i].rd = 5'd0; hist[i].we = 1'b0; hist[i].ld = 1'b0; hist[i].val = 32'd0;
        end
    endtask

    // Youngest producer of src wins; a load still in MEM cannot supply data.
    task automatic model_fwd(input logic [4:0] src, input logic [31:0] rf,
                             output logic [1:0] sel, output logic [31:0] data);
        sel = 2'd0; data = rf;
        if (src != 5'd0) begin
            for (int i = 1; i >= 0; i--) begin
                if (hist[i].we && hist[i].rd == src && !(i == 0 && hist[i].ld)) begin
                    sel = 2'(i + 1); data = hist[i].val;
                end
            end
        end
    endtask

    task automatic model_stall(output logic st, output int nm);
        logic haz;
        haz = exIsLoad && exRegWrite && exRdAddr != 5'd0 &&
              (exRdAddr == idRs1Addr || exRdAddr == idRs2Addr);
        st = 1'b0; nm = 0;
        if (!rst) begin
            if (m_mode == 2) begin
                st = memWait; nm = memWait ? 2 : 0;
            end else if (m_mode == 1) begin
                st = 1'b0; nm = memWait ? 2 : 0;
            end else begin
                st = memWait || haz;
                nm = memWait ? 2 : (haz ? 1 : 0);
            end
        end
    endtask

    // Advance the model across a rising edge using the inputs held before it.
    task automatic model_edge();
        rec_t r;
        if (rst) begin
            clear_hist(); m_mode = 0; m_cnt = 16'd0;
        end else begin
            if (m_stall && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
            m_mode = m_next_mode;
            if (!memWait) begin
                r = hist[0];
                if (r.ld) begin r.val = memLoadData; r.ld = 1'b0; end
                hist[1] = r;
                hist[0].rd = exRdAddr; hist[0].we = exRegWrite;
                hist[0].ld = exIsLoad; hist[0].val = exResult;
            end
        end
    endtask

    task automatic set_idle();
        n_rst = 1'b0; n_exRegWrite = 1'b0; n_exIsLoad = 1'b0; n_memWait = 1'b0;
        n_exRs1Addr = 5'd0; n_exRs2Addr = 5'd0; n_exRdAddr = 5'd0;
        n_idRs1Addr = 5'd0; n_idRs2Addr = 5'd0;
        n_exRs1Data = 32'd0; n_exRs2Data = 32'd0; n_exResult = 32'd0; n_memLoadData = 32'd0;
    endtask

    // One clock: update model, apply staged inputs, push expected outputs.
    task automatic step();
        exp_t e;
        @(posedge clk); #1;
        model_edge();
        rst = n_rst; exRegWrite = n_exRegWrite; exIsLoad = n_exIsLoad; memWait = n_memWait;
        exRs1Addr = n_exRs1Addr; exRs2Addr = n_exRs2Addr; exRdAddr = n_exRdAddr;
        idRs1Addr = n_idRs1Addr; idRs2Addr = n_idRs2Addr;
        exRs1Data = n_exRs1Data; exRs2Data = n_exRs2Data; exResult = n_exResult;
        memLoadData = n_memLoadData;
        model_stall(m_stall, m_next_mode);
        model_fwd(exRs1Addr, exRs1Data, e.s1, e.d1);
        model_fwd(exRs2Addr, exRs2Data, e.s2, e.d2);
        e.st = m_stall; e.cnt = m_cnt;
        sb.push_back(e);
    endtask

    task automatic do_reset();
        set_idle(); n_rst = 1'b1; step();
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: compares DUT outputs to the scoreboard every falling edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                checks++;
                if ({fwdSel1, fwdData1, fwdSel2, fwdData2, stall, stallCount} !== e) begin
                    errors++;
                    $display("FAIL scoreboard t=%0t got s1=%0d d1=%h s2=%0d d2=%h st=%b cnt=%0d exp s1=%0d d1=%h s2=%0d d2=%h st=%b cnt=%0d",
                             $time, fwdSel1, fwdData1, fwdSel2, fwdData2, stall, stallCount,
                             e.s1, e.d1, e.s2, e.d2, e.st, e.cnt);
                end
            end
        end
    end

    initial begin
        clear_hist(); m_mode = 0; m_next_mode = 0; m_cnt = 16'd0; m_stall = 1'b0;
        do_reset(); do_reset();
        #2;
        chk("reset_stall", 32'(stall), 32'd0);
        chk("reset_sel1", 32'(fwdSel1), 32'd0);
        chk("reset_cnt", 32'(stallCount), 32'd0);

        // Dependency chain: distance 1 then distance 2.
        set_idle(); n_exRdAddr = 5'd5; n_exRegWrite = 1'b1; n_exResult = 32'h11; step();
        set_idle(); n_exRs1Addr = 5'd5; n_exRs1Data = 32'h99; n_exRdAddr = 5'd6;
        n_exRegWrite = 1'b1; n_exResult = 32'h22; step(); #2;
        chk("chain_d1_sel", 32'(fwdSel1), 32'd1);
        chk("chain_d1_data", fwdData1, 32'h11);
        set_idle(); n_exRs2Addr = 5'd5; n_exRs2Data = 32'h98; n_exRs1Addr = 5'd6; step(); #2;
        chk("chain_d2_sel", 32'(fwdSel2), 32'd2);
        chk("chain_d2_data", fwdData2, 32'h11);
        chk("chain_d1b_data", fwdData1, 32'h22);
        set_idle(); n_exRs1Addr = 5'd5; n_exRs1Data = 32'h77; step(); #2;
        chk("chain_d3_sel", 32'(fwdSel1), 32'd0);
        chk("chain_d3_data", fwdData1, 32'h77);

        // MEM beats WB; x0 never forwards.
        do_reset();
        set_idle(); n_exRdAddr = 5'd7; n_exRegWrite = 1'b1; n_exResult = 32'hBB; step();
        set_idle(); n_exRdAddr = 5'd7; n_exRegWrite = 1'b1; n_exResult = 32'hAA; step();
        set_idle(); n_exRs1Addr = 5'd7; n_exRs2Addr = 5'd7; step(); #2;
        chk("prio_sel", 32'(fwdSel1), 32'd1);
        chk("prio_data", fwdData1, 32'hAA);
        set_idle(); n_exRdAddr = 5'd0; n_exRegWrite = 1'b1; n_exResult = 32'h55; step();
        set_idle(); n_exRs1Addr = 5'd0; n_exRs1Data = 32'h123; step(); #2;
        chk("x0_sel", 32'(fwdSel1), 32'd0);
        chk("x0_data", fwdData1, 32'h123);

        // Load-use: one stall, one bubble, then WB forward of the load data.
        do_reset();
        set_idle(); n_exRdAddr = 5'd3; n_exRegWrite = 1'b1; n_exIsLoad = 1'b1;
        n_exResult = 32'h40; n_idRs2Addr = 5'd3; step(); #2;
        chk("lu_stall", 32'(stall), 32'd1);
        set_idle(); n_memLoadData = 32'hDEAD; step(); #2;
        chk("lu_bubble", 32'(stall), 32'd0);
        set_idle(); n_exRs2Addr = 5'd3; n_exRs2Data = 32'h5; step(); #2;
        chk("lu_sel", 32'(fwdSel2), 32'd2);
        chk("lu_data", fwdData2, 32'hDEAD);
        chk("lu_cnt", 32'(stallCount), 32'd1);

        // Cache wait for 3 cycles with a MEM hit pending.
        do_reset();
        set_idle(); n_exRdAddr = 5'd9; n_exRegWrite = 1'b1; n_exResult = 32'h77; step();
        for (int i = 0; i < 3; i++) begin
            set_idle(); n_exRs1Addr = 5'd9; n_memWait = 1'b1; n_exRdAddr = 5'd9;
            n_exRegWrite = 1'b1; n_exResult = $urandom; step(); #2;
            chk("wait_stall", 32'(stall), 32'd1);
            chk("wait_data", fwdData1, 32'h77);
        end
        set_idle(); n_exRs1Addr = 5'd9; step(); #2;
        chk("wait_exit_stall", 32'(stall), 32'd0);
        chk("wait_cnt", 32'(stallCount), 32'd3);
        chk("wait_hold_data", fwdData1, 32'h77);

        // Cache wait outranks load-use; hazard is taken after the wait ends.
        do_reset();
        set_idle(); n_exRdAddr = 5'd4; n_exRegWrite = 1'b1; n_exIsLoad = 1'b1;
        n_idRs1Addr = 5'd4; n_memWait = 1'b1; step(); #2;
        chk("wl_stall0", 32'(stall), 32'd1);
        step(); #2;
        chk("wl_stall1", 32'(stall), 32'd1);
        n_memWait = 1'b0; step(); #2;
        chk("wl_exit", 32'(stall), 32'd0);
        step(); #2;
        chk("wl_lu", 32'(stall), 32'd1);
        set_idle(); step(); #2;
        chk("wl_bubble", 32'(stall), 32'd0);
        chk("wl_cnt", 32'(stallCount), 32'd3);

        // Reset during a cache wait.
        do_reset();
        set_idle(); n_exRdAddr = 5'd9; n_exRegWrite = 1'b1; n_exResult = 32'h77; step();
        set_idle(); n_exRs1Addr = 5'd9; n_memWait = 1'b1; step(); step();
        n_rst = 1'b1; step(); #2;
        chk("rstw_forced", 32'(stall), 32'd0);
        set_idle(); n_exRs1Addr = 5'd9; n_exRs1Data = 32'h31; step(); #2;
        chk("rstw_stall", 32'(stall), 32'd0);
        chk("rstw_sel", 32'(fwdSel1), 32'd0);
        chk("rstw_cnt", 32'(stallCount), 32'd0);

        // Random traffic checked by the scoreboard.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            n_rst = ($urandom_range(0, 99) == 0);
            n_exRs1Addr = 5'($urandom_range(0, 7)); n_exRs2Addr = 5'($urandom_range(0, 7));
            n_exRdAddr = 5'($urandom_range(0, 7));
            n_idRs1Addr = 5'($urandom_range(0, 7)); n_idRs2Addr = 5'($urandom_range(0, 7));
            n_exRegWrite = ($urandom_range(0, 9) < 7);
            n_exIsLoad = ($urandom_range(0, 3) == 0);
            n_memWait = ($urandom_range(0, 5) == 0);
            n_exRs1Data = $urandom; n_exRs2Data = $urandom;
            n_exResult = $urandom; n_memLoadData = $urandom;
            step();
        end

        // Counter saturation.
        do_reset();
        set_idle(); n_memWait = 1'b1;
        repeat (65541) step();
        set_idle(); step(); #2;
        chk("sat_cnt", 32'(stallCount), 32'h0000FFFF);
        chk("sat_stall", 32'(stall), 32'd0);

        @(negedge clk); #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
